// File: rtl/i2c_pkg.sv
// Shared I2C definitions: instruction codes, engine state encoding and bit-slot phase indices.
// Used by i2c_engine and by the bus clients that drive its instruction interface.
package i2c_pkg;

  localparam logic [1:0] INST_START_TX   = 2'd0;
  localparam logic [1:0] INST_STOP_TX    = 2'd1;
  localparam logic [1:0] INST_READ_BYTE  = 2'd2;
  localparam logic [1:0] INST_WRITE_BYTE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } i2c_state_e;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam logic [3:0] LAST_DATA_SLOT = 4'd7;
  localparam logic [3:0] ACK_SLOT       = 4'd8;

  function automatic i2c_state_e op_state(input logic [1:0] inst);
    case (inst)
      INST_START_TX:  return ST_START;
      INST_STOP_TX:   return ST_STOP;
      INST_READ_BYTE: return ST_READ;
      default:        return ST_WRITE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_engine_quarter_timer.sv
// Quarter-SCL-period timer: emits a one-cycle tick every QUARTER_CYCLES clocks while running
// and tracks the 2-bit phase of the current bit slot; hold_i freezes both.
module i2c_quarter_timer #(
  parameter int unsigned QUARTER_CYCLES = 67
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       hold_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);

  localparam int unsigned CW = (QUARTER_CYCLES > 2) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUARTER_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;

  assign tick_o  = run_i && !hold_i && (r_cnt == LAST);
  assign phase_o = r_phase;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !run_i) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (!hold_i) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_phase <= r_phase + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_engine.sv
// Byte-level I2C master executing one START/STOP/READ_BYTE/WRITE_BYTE primitive per request.
// Optional clock stretching support is enabled with `define I2C_CLOCK_STRETCH_EN.
module i2c_engine
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER_CYCLES = 67
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] instruction_i,
  input  logic       enable_i,
  input  logic [7:0] byte_to_send_i,
  output logic [7:0] byte_received_o,
  output logic       complete_o,
  output logic       nack_o,
  output logic       scl_o,
  output logic       sda_oe_o,
  input  logic       sda_i,
  input  logic       scl_i
);

  i2c_state_e r_state;
  logic [3:0] r_slot;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rcv;
  logic       r_scl;
  logic       r_sda_oe;
  logic       r_nack;

  logic       w_run;
  logic       w_hold;
  logic       w_tick;
  logic [1:0] w_phase;
  logic       w_last_slot;

  assign w_run       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_last_slot = (r_state == ST_START || r_state == ST_STOP) ? (r_slot == '0)
                                                                   : (r_slot == ACK_SLOT);

`ifdef I2C_CLOCK_STRETCH_EN
  // After SCL is released at p1, wait for the pin to actually read high before timing p2.
  logic r_wait_scl;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !w_run) begin
      r_wait_scl <= 1'b0;
    end else if (w_tick && w_phase == PH_1) begin
      r_wait_scl <= 1'b1;
    end else if (scl_i) begin
      r_wait_scl <= 1'b0;
    end
  end

  assign w_hold = r_wait_scl && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_hold       = 1'b0;
`endif

  i2c_quarter_timer #(
    .QUARTER_CYCLES(QUARTER_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run_i  (w_run),
    .hold_i (w_hold),
    .tick_o (w_tick),
    .phase_o(w_phase)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_slot   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rcv    <= '0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
      r_nack   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_state <= op_state(instruction_i);
            r_tx    <= byte_to_send_i;
            r_slot  <= '0;
          end
        end
        ST_DONE: begin
          if (!enable_i) r_state <= ST_IDLE;
        end
        default: begin
          if (w_tick) begin
            case (r_state)
              ST_START: begin
                case (w_phase)
                  PH_0:    r_sda_oe <= 1'b0;
                  PH_1:    r_scl    <= 1'b1;
                  PH_2:    r_sda_oe <= 1'b1;
                  default: r_scl    <= 1'b0;
                endcase
              end
              ST_STOP: begin
                case (w_phase)
                  PH_0:    r_sda_oe <= 1'b1;
                  PH_1:    r_scl    <= 1'b1;
                  PH_2:    r_sda_oe <= 1'b0;
                  default: ;
                endcase
              end
              ST_WRITE: begin
                case (w_phase)
                  PH_0: r_sda_oe <= (r_slot == ACK_SLOT) ? 1'b0 : ~r_tx[7];
                  PH_1: r_scl    <= 1'b1;
                  PH_2: if (r_slot == ACK_SLOT) r_nack <= sda_i;
                  default: begin
                    r_scl <= 1'b0;
                    r_tx  <= {r_tx[6:0], 1'b0};
                  end
                endcase
              end
              ST_READ: begin
                case (w_phase)
                  PH_0: r_sda_oe <= (r_slot == ACK_SLOT);
                  PH_1: r_scl    <= 1'b1;
                  PH_2: if (r_slot != ACK_SLOT) r_rx <= {r_rx[6:0], sda_i};
                  default: begin
                    r_scl <= 1'b0;
                    if (r_slot == LAST_DATA_SLOT) r_rcv <= r_rx;
                  end
                endcase
              end
              default: ;
            endcase
            if (w_phase == PH_3) begin
              if (w_last_slot) r_state <= ST_DONE;
              else             r_slot  <= r_slot + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign byte_received_o = r_rcv;
  assign complete_o      = (r_state == ST_DONE);
  assign nack_o          = r_nack;
  assign scl_o           = r_scl;
  assign sda_oe_o        = r_sda_oe;

endmodule

// File: tb/tb_i2c_engine.sv
// Self-checking bench for i2c_engine with QUARTER_CYCLES=4: vector table plus a bus/target
// model on SDA/SCL, with a scoreboard of expected per-operation results.
module tb_i2c_engine;

  localparam int unsigned Q = 4;
  localparam logic [1:0] I_START = 2'd0, I_STOP = 2'd1, I_READ = 2'd2, I_WRITE = 2'd3;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [1:0] instruction_i;
  logic       enable_i;
  logic [7:0] byte_to_send_i;
  logic [7:0] byte_received_o;
  logic       complete_o;
  logic       nack_o;
  logic       scl_o;
  logic       sda_oe_o;
  logic       sda_i;
  logic       scl_i;

  always #5 clk = ~clk;

  i2c_engine #(.QUARTER_CYCLES(Q)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instruction_i  (instruction_i),
    .enable_i       (enable_i),
    .byte_to_send_i (byte_to_send_i),
    .byte_received_o(byte_received_o),
    .complete_o     (complete_o),
    .nack_o         (nack_o),
    .scl_o          (scl_o),
    .sda_oe_o       (sda_oe_o),
    .sda_i          (sda_i),
    .scl_i          (scl_i)
  );

  // Target model: tracks bit slots via SCL falls, drives read data / ACK, records bus events.
  logic [1:0] cur_inst = I_START;
  logic [7:0] rd_data = '0;
  logic       ack_en = 1'b0;
  logic       stretch_hold = 1'b0;
  logic       target_pull;
  logic       sda_line;
  int         slot = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_en = 1'b0;
  logic [8:0] bits_sh = '0, oe_sh = '0;
  int         n_start = 0, n_stop = 0;

  always_comb begin
    target_pull = 1'b0;
    if (cur_inst == I_WRITE && slot == 8) target_pull = ack_en;
    if (cur_inst == I_READ && slot < 8)   target_pull = !rd_data[7-slot];
  end
  assign sda_line = ~(sda_oe_o | target_pull);
  assign sda_i    = sda_line;
  assign scl_i    = scl_o & ~stretch_hold;

  always @(posedge clk) begin
    prev_scl <= scl_o;
    prev_sda <= sda_line;
    prev_en  <= enable_i;
    if (enable_i && !prev_en) slot <= 0;
    else if (prev_scl && !scl_o) slot <= slot + 1;
    if (!prev_scl && scl_o) begin
      bits_sh <= {bits_sh[7:0], sda_line};
      oe_sh   <= {oe_sh[7:0], sda_oe_o};
    end
    if (rst_ni && prev_scl && scl_o && prev_sda && !sda_line) n_start <= n_start + 1;
    if (rst_ni && prev_scl && scl_o && !prev_sda && sda_line) n_stop <= n_stop + 1;
  end

  typedef struct {
    logic [1:0] inst;
    logic [7:0] wbyte;
    logic [7:0] rdata;
    logic       ack;
    int         lat;
    logic [7:0] rx;
    logic       nack;
    logic       chk_bus;
    logic [8:0] bits;
    logic [8:0] oe;
    int         starts;
    int         stops;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input int stretch);
    vec_t e;
    int   lat, s0, p0, left;
    bit   done, seen;
    @(negedge clk);
    check("complete_low_before_enable", complete_o, 0);
    cur_inst = v.inst; rd_data = v.rdata; ack_en = v.ack;
    instruction_i = v.inst; byte_to_send_i = v.wbyte;
    stretch_hold = (stretch > 0);
    s0 = n_start; p0 = n_stop;
    sb.push_back(v);
    enable_i = 1'b1;
    lat = 0; done = 0; seen = 0; left = stretch;
    while (!done && lat < 2000) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (complete_o) done = 1;
      if (stretch_hold) begin
        if (seen) begin
          left--;
          if (left == 0) stretch_hold = 1'b0;
        end else if (scl_o) seen = 1;
      end
    end
    check("op_completes_in_budget", done, 1);
    e = sb.pop_front();
    check("latency", lat, e.lat + stretch);
    check("byte_received", byte_received_o, e.rx);
    check("nack", nack_o, e.nack);
    if (e.chk_bus) begin
      check("sda_bits_at_scl_rise", bits_sh, e.bits);
      check("sda_oe_at_scl_rise", oe_sh, e.oe);
    end
    check("start_conditions", n_start - s0, e.starts);
    check("stop_conditions", n_stop - p0, e.stops);
    @(posedge clk); @(negedge clk);
    check("complete_held_while_enabled", complete_o, 1);
    enable_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("complete_low_after_drop", complete_o, 0);
  endtask

  initial begin
    int lat, s0, p0;
    vecs[0] = '{I_START, 8'h00, 8'h00, 1'b0,  17, 8'h00, 1'b0, 1'b0, 9'h000, 9'h000, 1, 0};
    vecs[1] = '{I_WRITE, 8'h90, 8'h00, 1'b1, 145, 8'h00, 1'b0, 1'b1, 9'h120, 9'h0DE, 0, 0};
    vecs[2] = '{I_WRITE, 8'h91, 8'h00, 1'b0, 145, 8'h00, 1'b1, 1'b1, 9'h123, 9'h0DC, 0, 0};
    vecs[3] = '{I_START, 8'h00, 8'h00, 1'b0,  17, 8'h00, 1'b1, 1'b0, 9'h000, 9'h000, 1, 0};
    vecs[4] = '{I_READ,  8'hFF, 8'hA5, 1'b0, 145, 8'hA5, 1'b1, 1'b1, 9'h14A, 9'h001, 0, 0};
    vecs[5] = '{I_WRITE, 8'h3C, 8'h00, 1'b1, 145, 8'hA5, 1'b0, 1'b1, 9'h078, 9'h186, 0, 0};
    vecs[6] = '{I_STOP,  8'h00, 8'h00, 1'b0,  17, 8'hA5, 1'b0, 1'b0, 9'h000, 9'h000, 0, 1};

    rst_ni = 1'b0; enable_i = 1'b0; instruction_i = I_START; byte_to_send_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_scl", scl_o, 1);
    check("reset_sda_oe", sda_oe_o, 0);
    check("reset_complete", complete_o, 0);
    check("reset_nack", nack_o, 0);
    check("reset_byte_received", byte_received_o, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) do_op(vecs[i], 0);
    check("bus_idle_scl", scl_o, 1);
    check("bus_idle_sda", sda_line, 1);

    // enable dropped and inputs changed mid-op: START still runs, complete pulses one cycle
    @(negedge clk);
    cur_inst = I_START; instruction_i = I_START; enable_i = 1'b1;
    s0 = n_start; p0 = n_stop; lat = 0;
    repeat (3) begin @(posedge clk); lat++; end
    @(negedge clk);
    enable_i = 1'b0; instruction_i = I_STOP; byte_to_send_i = 8'hFF;
    while (!complete_o && lat < 500) begin @(posedge clk); lat++; @(negedge clk); end
    check("dropped_enable_latency", lat, 17);
    check("dropped_enable_start_seen", n_start - s0, 1);
    check("dropped_enable_no_stop", n_stop - p0, 0);
    @(posedge clk); @(negedge clk);
    check("complete_single_cycle", complete_o, 0);

    // reset during bit 3 of a WRITE
    cur_inst = I_WRITE; ack_en = 1'b1; instruction_i = I_WRITE; byte_to_send_i = 8'h0F;
    enable_i = 1'b1;
    lat = 0;
    @(posedge clk);
    while (slot != 3 && lat < 500) begin @(posedge clk); lat++; end
    check("reached_write_bit3", slot, 3);
    @(negedge clk);
    rst_ni = 1'b0; enable_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midop_reset_scl", scl_o, 1);
    check("midop_reset_sda_oe", sda_oe_o, 0);
    check("midop_reset_complete", complete_o, 0);
    check("midop_reset_nack", nack_o, 0);
    check("midop_reset_byte_received", byte_received_o, 0);
    rst_ni = 1'b1;
    vecs[0].rx = 8'h00; vecs[0].nack = 1'b0;
    do_op(vecs[0], 0);

`ifdef I2C_CLOCK_STRETCH_EN
    // repeated START with SCL held low by the target for 20 cycles after release
    vecs[1].rx = 8'h00;
    do_op(vecs[1], 0);
    vecs[0].nack = 1'b0;
    do_op(vecs[0], 20);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_engine.md
Name: i2c_engine

Overview:
Byte-level I2C master that executes one bus primitive per request: START (or repeated START), STOP, WRITE_BYTE or READ_BYTE. It is the responder on the instruction interface used by bus clients such as the ADC controller and OLED driver. It drives SCL and open-drain SDA to the board pins at roughly 100 kHz from the 27 MHz system clock.

Parameters:
QUARTER_CYCLES, 67, clk_i cycles per quarter SCL period (27 MHz / (4 × 67) ≈ 100.7 kHz); minimum 2.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; synchronous, active-low
instruction_i  in  2  0=START, 1=STOP, 2=READ_BYTE, 3=WRITE_BYTE; sampled on acceptance
enable_i  in  1  request; client holds it high until complete_o is seen
byte_to_send_i  in  8  WRITE_BYTE payload, MSB first; sampled on acceptance
byte_received_o  out  8  last READ_BYTE result
complete_o  out  1  high while in DONE
nack_o  out  1  ACK bit sampled on last WRITE_BYTE (1 = NACK)
scl_o  out  1  SCL level
sda_oe_o  out  1  1 = pull SDA low, 0 = release; top level builds the tri-state
sda_i  in  1  SDA pin readback
scl_i  in  1  SCL pin readback; used only with I2C_CLOCK_STRETCH_EN

Behaviour:
- Reset values: scl_o=1, sda_oe_o=0, complete_o=0, nack_o=0, byte_received_o=0, state IDLE, quarter counter 0.
- States: IDLE, START, STOP, WRITE, READ, DONE.
- IDLE:
  - enable_i=1 → latch instruction_i and byte_to_send_i, clear the quarter counter, enter the op state next cycle.
  - complete_o=0 in IDLE.
- Quarter tick:
  - Fires every QUARTER_CYCLES cycles inside an op state.
  - Each bit slot has 4 phases, p0..p3.
- START (1 slot):
  - p0: release SDA.
  - p1: scl_o=1.
  - p2: SDA low.
  - p3: scl_o=0.
  - Works from idle bus and as repeated START (SCL low).
- STOP (1 slot):
  - p0: SDA low.
  - p1: scl_o=1.
  - p2: release SDA.
  - p3: hold; SCL stays 1.
- WRITE (9 slots):
  - Slots 0–7: p0 sets sda_oe_o = ~bit (bit7 first); p1 scl_o=1; p2 hold; p3 scl_o=0.
  - Slot 8: SDA released; nack_o <= sda_i sampled at the p2 tick.
- READ (9 slots):
  - Slots 0–7: SDA released; sda_i shifted in MSB first at each p2 tick.
  - byte_received_o updated once, at the end of slot 7.
  - Slot 8: master drives ACK (SDA low). READ_BYTE always ACKs; the client ends the transfer with STOP.
- Op end: after the last p3 tick → DONE.
- DONE:
  - complete_o=1.
  - When enable_i=0 → IDLE next cycle.
  - If enable_i is already low on entry, complete_o is high for exactly 1 cycle.
- Latency: accept cycle + slots × 4 × QUARTER_CYCLES cycles, then complete_o rises. START/STOP = 4Q; READ/WRITE = 36Q.
- enable_i dropping mid-op: ignored; the op runs to completion.
- New inputs during an op: ignored; instruction and byte were latched at acceptance.
- Reset mid-op: all outputs return to reset values next edge. The bus is left released (SCL=1, SDA released). No STOP is generated.
- Client contract: a client seeing complete_o low and then high drops enable_i. The engine guarantees complete_o is low again before the next acceptance.

Optional Feature:
- Macro I2C_CLOCK_STRETCH_EN.
- Defined: at each p1 tick (SCL released high), the quarter counter freezes until scl_i reads 1. The next phase's full quarter is then counted from that point. Slow targets can stretch the clock.
- Undefined: scl_i is ignored and timing is purely counter-based.

Decomposition:
- Package i2c_pkg holds:
  - instruction codes INST_START_TX=0, INST_STOP_TX=1, INST_READ_BYTE=2, INST_WRITE_BYTE=3;
  - the engine state encoding;
  - the phase indices.
  - Shared with adc and other clients.
- One sub-module, i2c_quarter_timer: counter producing the quarter tick and 2-bit phase index, with a hold input for clock stretching.

Test Plan:
1. QUARTER_CYCLES=4, START from reset → SDA falls while scl_o=1, then scl_o=0; complete_o rises at cycle 17; enable_i low → complete_o low next cycle.
2. WRITE_BYTE 0x90, bus model ACKs (sda_i=0 in slot 8) → SDA bits sampled on SCL rising edges read 1,0,0,1,0,0,0,0; nack_o=0; latency 145 cycles.
3. WRITE_BYTE 0x91 with no ACK (sda_i=1) → nack_o=1; complete_o still asserted.
4. READ_BYTE, model drives 0xA5 → byte_received_o=0xA5; sda_oe_o=1 during slot 8 (ACK); sda_oe_o=0 during slots 0–7.
5. Sequence START, WRITE, STOP with enable_i dropped 1 cycle after each complete → STOP edge shows SDA rising while SCL=1; bus idle afterwards; complete_o low before every re-enable.
6. rst_ni low at bit 3 of a WRITE → next edge: scl_o=1, sda_oe_o=0, complete_o=0; new START accepted immediately after release. With I2C_CLOCK_STRETCH_EN, scl_i held 0 for 20 cycles → phase progression pauses exactly 20 cycles.
